vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator with a latency-matched pixel pipeline. It produces request coordinates for the upstream frame/character source. It then delays the sync and valid signals by a programmable number of cycles, so they line up with data returned from synchronous memories. It also supplies character-cell coordinates using running counters instead of dividers. It sits between the pixel-clock domain top level and the VGA DAC pins, and is the drop-in successor to the fixed 640x480 controller.

## Interface
- H_SYNC, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch
- V_SYNC, 2 / V_BP, 33 / V_ACTIVE, 480 / V_FP, 10: vertical equivalents, in lines
- HS_POL, 0 / VS_POL, 0: sync pulse level during the sync interval (0 = negative pulse)
- LAT, 2: upstream read latency in cycles, legal range 1..8
- CELL_W, 9 / CELL_H, 16: character cell size in pixels, each ≥1
- AW, 10: coordinate width; must hold H_ACTIVE-1 and V_ACTIVE-1
- Ports:
  - pclk  in  1  pixel clock
  - reset_n  in  1  asynchronous, active-low reset
  - blank  in  1  forces RGB to 0; syncs keep running
  - vga_data  in  24  {R,G,B}, returned LAT cycles after the request
  - h_addr, v_addr  out  AW  request pixel coordinates; 0 outside active region
  - req_valid  out  1  request coordinates are inside the active area
  - cell_x, cell_y  out  AW  cell index of the request pixel
  - cell_px, cell_py  out  5  offset within the cell
  - frame_start  out  1  one-cycle pulse, aligned to output
  - line_start  out  1  one-cycle pulse, aligned to output
  - hsync, vsync, valid  out  1  registered, latency-aligned
  - vga_r, vga_g, vga_b  out  8  registered colour

## Operation
- Horizontal counter hc runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. It wraps to 0.
- Vertical counter vc increments when hc wraps and runs 0..V_TOTAL-1. It wraps to 0 when hc and vc are both at terminal count in the same cycle.
- Region order within each line and frame: sync, back porch, active, front porch.
  - Sync is asserted for hc < H_SYNC.
  - Horizontal active is hc in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE). Vertical rules are analogous.
- Request-stage signals are combinational from the counter registers:
  - req_valid = h_act & v_act
  - h_addr = hc − (H_SYNC+H_BP) when h_act, else 0
  - v_addr follows the same rule on vc
- Cell counters:
  - cell_px and cell_x clear on the first active pixel of each line. cell_px increments per active pixel and wraps at CELL_W−1, at which point cell_x increments.
  - cell_py and cell_y clear on the first active line. They advance at the end of each active line and wrap at CELL_H−1.
  - All cell outputs are 0 outside the active region.
- Delay line: {hsync_raw, vsync_raw, req_valid, frame_start_raw, line_start_raw} is shifted through LAT stages.
- Output registers sample the final stage:
  - vga_{r,g,b} = (valid_d & ~blank_d) ? vga_data : 0
  - blank is delayed LAT stages with the other signals.
- Sync level: hsync = HS_POL when in sync, else ~HS_POL; vsync uses VS_POL the same way.
- Raw pulses: frame_start_raw is asserted at hc=0, vc=0; line_start_raw at hc=0.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - hc, vc, cell counters, delay stages: 0 / inactive
  - hsync = ~HS_POL, vsync = ~VS_POL
  - valid, frame_start, line_start, vga_* = 0
- First edge after reset release: hc=1. Request outputs reflect hc=0 during the first cycle.
- Output alignment: the request at cycle t appears on hsync/vsync/valid/rgb at cycle t+LAT+1. vga_data must be stable during cycle t+LAT.
- Reset asserted mid-frame: all state clears immediately. No partial pulse may be stretched; the next frame begins at hc=vc=0.
- blank toggling takes effect at the output LAT+1 cycles later, pixel-exact.
- Frame period is H_TOTAL·V_TOTAL cycles, with no missing or duplicate lines at the vc wrap.

## Test plan
- Defaults, release reset: hsync low for 96 cycles, then high for 704. Period 800. vsync low for 2 lines (1600 cycles) per 525 lines.
- Defaults, LAT=2: first valid=1 at 147 cycles plus the line offset of the first active line (35·800). Ramp vga_data = h_addr on request → vga_r/g/b outputs 0,1,2… starting exactly at the valid rising edge.
- CELL_W=9: at h_addr 8 → cell_x=0, cell_px=8. At h_addr 9 → cell_x=1, cell_px=0. At h_addr 639 → cell_x=71, cell_px=0. v_addr 479 → cell_y=29, cell_py=15.
- blank pulsed for 10 request cycles mid-line → exactly 10 consecutive output pixels at 0; hsync is unaffected.
- reset_n low for 3 cycles at hc=400, vc=200 → outputs go to reset values asynchronously. After release, frame_start pulses at output cycle LAT+1.
- Small config H 2/2/4/2, V 1/1/3/1, LAT=1, HS_POL=1 → 10-cycle lines, 6-line frames, positive hsync pulses. frame_start appears every 60 cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
// Produces request coordinates and character-cell coordinates for an upstream
// pixel source, then delays sync/valid/blank by LAT cycles so they line up with
// the colour data that source returns, and registers everything at the pins.
module vga_timing_gen #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   LAT      = 2,
    parameter int   CELL_W   = 9,
    parameter int   CELL_H   = 16,
    parameter int   AW       = 10
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          blank,
    input  logic [23:0]   vga_data,
    output logic [AW-1:0] h_addr,
    output logic [AW-1:0] v_addr,
    output logic          req_valid,
    output logic [AW-1:0] cell_x,
    output logic [AW-1:0] cell_y,
    output logic [4:0]    cell_px,
    output logic [4:0]    cell_py,
    output logic          frame_start,
    output logic          line_start,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_SYNC);
    localparam logic [HCW-1:0] H_ACT_BEG  = HCW'(H_SYNC + H_BP);
    localparam logic [HCW-1:0] H_ACT_LAST = HCW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_SYNC);
    localparam logic [VCW-1:0] V_ACT_BEG  = VCW'(V_SYNC + V_BP);
    localparam logic [VCW-1:0] V_ACT_LAST = VCW'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [4:0]     CW_LAST    = 5'(CELL_W - 1);
    localparam logic [4:0]     CH_LAST    = 5'(CELL_H - 1);

    // Delay-line bit positions; idle value keeps syncs at their inactive level.
    localparam int P_HS    = 5;
    localparam int P_VS    = 4;
    localparam int P_VALID = 3;
    localparam int P_FS    = 2;
    localparam int P_LS    = 1;
    localparam int P_BLANK = 0;
    localparam logic [5:0] PIPE_IDLE = {~HS_POL, ~VS_POL, 4'b0000};

    logic [HCW-1:0] hc_q, hc_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic           h_wrap;
    logic           h_act, v_act;
    logic           hsync_raw, vsync_raw, fs_raw, ls_raw;

    logic [4:0]     cpx_q, cpx_d, cpy_q, cpy_d;
    logic [AW-1:0]  cx_q, cx_d, cy_q, cy_d;

    logic [5:0]     pipe_q [LAT];
    logic [5:0]     pipe_d [LAT];
    logic [5:0]     tail;

    logic           hsync_q, hsync_d, vsync_q, vsync_d, valid_q, valid_d;
    logic           fs_q, fs_d, ls_q, ls_d;
    logic [23:0]    rgb_q, rgb_d;

    // Raster counters: hc wraps each line, vc advances on the hc wrap.
    always_comb begin
        h_wrap = (hc_q == H_LAST);
        hc_d   = h_wrap ? '0 : hc_q + HCW'(1);
        vc_d   = vc_q;
        if (h_wrap) begin
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + VCW'(1);
        end
    end

    // Request-stage decode, straight from the counter registers.
    always_comb begin
        h_act     = (hc_q >= H_ACT_BEG) && (hc_q <= H_ACT_LAST);
        v_act     = (vc_q >= V_ACT_BEG) && (vc_q <= V_ACT_LAST);
        req_valid = h_act && v_act;
        h_addr    = h_act ? AW'(hc_q - H_ACT_BEG) : '0;
        v_addr    = v_act ? AW'(vc_q - V_ACT_BEG) : '0;
        hsync_raw = (hc_q < H_SYNC_END) ? HS_POL : ~HS_POL;
        vsync_raw = (vc_q < V_SYNC_END) ? VS_POL : ~VS_POL;
        fs_raw    = (hc_q == '0) && (vc_q == '0);
        ls_raw    = (hc_q == '0);
        cell_px   = req_valid ? cpx_q : '0;
        cell_x    = req_valid ? cx_q  : '0;
        cell_py   = req_valid ? cpy_q : '0;
        cell_y    = req_valid ? cy_q  : '0;
    end

    // Running cell counters; cleared one cycle ahead so the first active pixel/line reads 0.
    always_comb begin
        cpx_d = cpx_q;
        cx_d  = cx_q;
        cpy_d = cpy_q;
        cy_d  = cy_q;
        if (hc_d == H_ACT_BEG) begin
            cpx_d = '0;
            cx_d  = '0;
        end else if (h_act) begin
            if (cpx_q == CW_LAST) begin
                cpx_d = '0;
                cx_d  = cx_q + AW'(1);
            end else begin
                cpx_d = cpx_q + 5'd1;
            end
        end
        if (h_wrap) begin
            if (vc_d == V_ACT_BEG) begin
                cpy_d = '0;
                cy_d  = '0;
            end else if (v_act) begin
                if (cpy_q == CH_LAST) begin
                    cpy_d = '0;
                    cy_d  = cy_q + AW'(1);
                end else begin
                    cpy_d = cpy_q + 5'd1;
                end
            end
        end
    end

    // Latency-matching delay line; blank travels with the request it applies to.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {hsync_raw, vsync_raw, req_valid, fs_raw, ls_raw, blank};
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Output stage: colour is taken while the last delay stage is presented.
    always_comb begin
        tail    = pipe_q[LAT-1];
        hsync_d = tail[P_HS];
        vsync_d = tail[P_VS];
        valid_d = tail[P_VALID];
        fs_d    = tail[P_FS];
        ls_d    = tail[P_LS];
        rgb_d   = (tail[P_VALID] && !tail[P_BLANK]) ? vga_data : 24'h0;
    end

    // All state registers; reset drops everything to the idle/inactive levels.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            cpx_q   <= '0;
            cx_q    <= '0;
            cpy_q   <= '0;
            cy_q    <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= PIPE_IDLE;
            end
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            rgb_q   <= 24'h0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            cpx_q   <= cpx_d;
            cx_q    <= cx_d;
            cpy_q   <= cpy_d;
            cy_q    <= cy_d;
            pipe_q  <= pipe_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign valid       = valid_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations run side by side against a
// cycle-index reference model; output expectations queue up for LAT+1 cycles.
module tb_vga_timing_gen;

    typedef struct packed {
        int   hs, hbp, ha, hfp, vs, vbp, va, vfp, cw, ch, lat;
        logic hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic [9:0] h_addr, v_addr;
        logic       req_valid;
        logic [9:0] cell_x, cell_y;
        logic [4:0] cell_px, cell_py;
    } req_t;

    typedef struct packed {
        logic        hsync, vsync, valid, fs, ls;
        logic [23:0] rgb;
    } out_t;

    localparam cfg_t CA = '{hs:96, hbp:48, ha:640, hfp:16, vs:2, vbp:33, va:480, vfp:10,
                            cw:9, ch:16, lat:2, hpol:1'b0, vpol:1'b0};
    localparam cfg_t CB = '{hs:2, hbp:2, ha:4, hfp:2, vs:1, vbp:1, va:3, vfp:1,
                            cw:3, ch:2, lat:1, hpol:1'b1, vpol:1'b0};
    localparam cfg_t CC = '{hs:1, hbp:1, ha:18, hfp:1, vs:1, vbp:1, va:480, vfp:1,
                            cw:9, ch:16, lat:3, hpol:1'b0, vpol:1'b1};

    logic pclk = 1'b0;
    logic reset_n, blank;
    always #5 pclk = ~pclk;

    logic [9:0]  a_h_addr, a_v_addr, a_cell_x, a_cell_y;
    logic [4:0]  a_cell_px, a_cell_py;
    logic        a_req_valid, a_frame_start, a_line_start, a_hsync, a_vsync, a_valid;
    logic [7:0]  a_r, a_g, a_b;
    logic [23:0] a_data;
    logic [9:0]  b_h_addr, b_v_addr, b_cell_x, b_cell_y;
    logic [4:0]  b_cell_px, b_cell_py;
    logic        b_req_valid, b_frame_start, b_line_start, b_hsync, b_vsync, b_valid;
    logic [7:0]  b_r, b_g, b_b;
    logic [23:0] b_data;
    logic [9:0]  c_h_addr, c_v_addr, c_cell_x, c_cell_y;
    logic [4:0]  c_cell_px, c_cell_py;
    logic        c_req_valid, c_frame_start, c_line_start, c_hsync, c_vsync, c_valid;
    logic [7:0]  c_r, c_g, c_b;
    logic [23:0] c_data;

    req_t a_req_obs, b_req_obs, c_req_obs;
    out_t a_out_obs, b_out_obs, c_out_obs;
    assign a_req_obs = {a_h_addr, a_v_addr, a_req_valid, a_cell_x, a_cell_y, a_cell_px, a_cell_py};
    assign b_req_obs = {b_h_addr, b_v_addr, b_req_valid, b_cell_x, b_cell_y, b_cell_px, b_cell_py};
    assign c_req_obs = {c_h_addr, c_v_addr, c_req_valid, c_cell_x, c_cell_y, c_cell_px, c_cell_py};
    assign a_out_obs = {a_hsync, a_vsync, a_valid, a_frame_start, a_line_start, a_r, a_g, a_b};
    assign b_out_obs = {b_hsync, b_vsync, b_valid, b_frame_start, b_line_start, b_r, b_g, b_b};
    assign c_out_obs = {c_hsync, c_vsync, c_valid, c_frame_start, c_line_start, c_r, c_g, c_b};

    vga_timing_gen #(
        .H_SYNC(CA.hs), .H_BP(CA.hbp), .H_ACTIVE(CA.ha), .H_FP(CA.hfp),
        .V_SYNC(CA.vs), .V_BP(CA.vbp), .V_ACTIVE(CA.va), .V_FP(CA.vfp),
        .HS_POL(CA.hpol), .VS_POL(CA.vpol), .LAT(CA.lat),
        .CELL_W(CA.cw), .CELL_H(CA.ch), .AW(10)
    ) dut_a (
        .pclk(pclk), .reset_n(reset_n), .blank(blank), .vga_data(a_data),
        .h_addr(a_h_addr), .v_addr(a_v_addr), .req_valid(a_req_valid),
        .cell_x(a_cell_x), .cell_y(a_cell_y), .cell_px(a_cell_px), .cell_py(a_cell_py),
        .frame_start(a_frame_start), .line_start(a_line_start),
        .hsync(a_hsync), .vsync(a_vsync), .valid(a_valid),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
    );

    vga_timing_gen #(
        .H_SYNC(CB.hs), .H_BP(CB.hbp), .H_ACTIVE(CB.ha), .H_FP(CB.hfp),
        .V_SYNC(CB.vs), .V_BP(CB.vbp), .V_ACTIVE(CB.va), .V_FP(CB.vfp),
        .HS_POL(CB.hpol), .VS_POL(CB.vpol), .LAT(CB.lat),
        .CELL_W(CB.cw), .CELL_H(CB.ch), .AW(10)
    ) dut_b (
        .pclk(pclk), .reset_n(reset_n), .blank(blank), .vga_data(b_data),
        .h_addr(b_h_addr), .v_addr(b_v_addr), .req_valid(b_req_valid),
        .cell_x(b_cell_x), .cell_y(b_cell_y), .cell_px(b_cell_px), .cell_py(b_cell_py),
        .frame_start(b_frame_start), .line_start(b_line_start),
        .hsync(b_hsync), .vsync(b_vsync), .valid(b_valid),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
    );

    vga_timing_gen #(
        .H_SYNC(CC.hs), .H_BP(CC.hbp), .H_ACTIVE(CC.ha), .H_FP(CC.hfp),
        .V_SYNC(CC.vs), .V_BP(CC.vbp), .V_ACTIVE(CC.va), .V_FP(CC.vfp),
        .HS_POL(CC.hpol), .VS_POL(CC.vpol), .LAT(CC.lat),
        .CELL_W(CC.cw), .CELL_H(CC.ch), .AW(10)
    ) dut_c (
        .pclk(pclk), .reset_n(reset_n), .blank(blank), .vga_data(c_data),
        .h_addr(c_h_addr), .v_addr(c_v_addr), .req_valid(c_req_valid),
        .cell_x(c_cell_x), .cell_y(c_cell_y), .cell_px(c_cell_px), .cell_py(c_cell_py),
        .frame_start(c_frame_start), .line_start(c_line_start),
        .hsync(c_hsync), .vsync(c_vsync), .valid(c_valid),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b)
    );

    int   k;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   first_valid_a, blank_px_a, b_last_fs;
    out_t qa[$];
    out_t qb[$];
    out_t qc[$];

    // Reference request outputs for cycle k after reset release (divider-based).
    function automatic req_t exp_req(cfg_t c, int kk);
        int   ht, vt, hc, vc;
        logic ha, va;
        req_t r;
        ht = c.hs + c.hbp + c.ha + c.hfp;
        vt = c.vs + c.vbp + c.va + c.vfp;
        hc = kk % ht;
        vc = (kk / ht) % vt;
        ha = (hc >= c.hs + c.hbp) && (hc < c.hs + c.hbp + c.ha);
        va = (vc >= c.vs + c.vbp) && (vc < c.vs + c.vbp + c.va);
        r  = '0;
        if (ha) r.h_addr = 10'(hc - c.hs - c.hbp);
        if (va) r.v_addr = 10'(vc - c.vs - c.vbp);
        r.req_valid = ha && va;
        if (r.req_valid) begin
            r.cell_x  = 10'(int'(r.h_addr) / c.cw);
            r.cell_px = 5'(int'(r.h_addr) % c.cw);
            r.cell_y  = 10'(int'(r.v_addr) / c.ch);
            r.cell_py = 5'(int'(r.v_addr) % c.ch);
        end
        return r;
    endfunction

    // Upstream source model: colour returned for the request made at cycle kk.
    function automatic logic [23:0] data_of(req_t r, int kk);
        return {r.h_addr[7:0], r.v_addr[7:0], 8'(kk)};
    endfunction

    function automatic out_t exp_out(cfg_t c, int kk, logic blk);
        int   ht, vt, hc, vc;
        req_t r;
        out_t o;
        ht = c.hs + c.hbp + c.ha + c.hfp;
        vt = c.vs + c.vbp + c.va + c.vfp;
        hc = kk % ht;
        vc = (kk / ht) % vt;
        r  = exp_req(c, kk);
        o.hsync = (hc < c.hs) ? c.hpol : ~c.hpol;
        o.vsync = (vc < c.vs) ? c.vpol : ~c.vpol;
        o.valid = r.req_valid;
        o.fs    = (hc == 0) && (vc == 0);
        o.ls    = (hc == 0);
        o.rgb   = (r.req_valid && !blk) ? data_of(r, kk) : 24'h0;
        return o;
    endfunction

    function automatic out_t idle_out(cfg_t c);
        out_t o;
        o       = '0;
        o.hsync = ~c.hpol;
        o.vsync = ~c.vpol;
        return o;
    endfunction

    task automatic chk_req(string tag, req_t obs, req_t exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_out(string tag, out_t obs, out_t exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic set_inputs();
        a_data = (k >= CA.lat) ? data_of(exp_req(CA, k - CA.lat), k - CA.lat) : 24'h0;
        b_data = (k >= CB.lat) ? data_of(exp_req(CB, k - CB.lat), k - CB.lat) : 24'h0;
        c_data = (k >= CC.lat) ? data_of(exp_req(CC, k - CC.lat), k - CC.lat) : 24'h0;
    endtask

    task automatic do_checks();
        chk_req("a_req", a_req_obs, exp_req(CA, k));
        qa.push_back(exp_out(CA, k, blank));
        chk_out("a_out", a_out_obs, qa.pop_front());
        chk_req("b_req", b_req_obs, exp_req(CB, k));
        qb.push_back(exp_out(CB, k, blank));
        chk_out("b_out", b_out_obs, qb.pop_front());
        chk_req("c_req", c_req_obs, exp_req(CC, k));
        qc.push_back(exp_out(CC, k, blank));
        chk_out("c_out", c_out_obs, qc.pop_front());
        if (a_valid && first_valid_a < 0) first_valid_a = k;
        if (a_valid && a_out_obs.rgb == 24'h0) blank_px_a++;
        if (b_frame_start) begin
            if (b_last_fs >= 0) chk_int("b_frame_period", k - b_last_fs, 60);
            b_last_fs = k;
        end
    endtask

    task automatic one_cycle();
        do_checks();
        @(posedge pclk);
        #1;
        k++;
        set_inputs();
    endtask

    task automatic run_to(int target);
        while (k < target) one_cycle();
    endtask

    // Called just after reset_n rises: cycle 0 is the one in which hc=0.
    task automatic start_run();
        k = 0;
        qa.delete();
        qb.delete();
        qc.delete();
        for (int i = 0; i <= CA.lat; i++) qa.push_back(idle_out(CA));
        for (int i = 0; i <= CB.lat; i++) qb.push_back(idle_out(CB));
        for (int i = 0; i <= CC.lat; i++) qc.push_back(idle_out(CC));
        b_last_fs = -1;
        set_inputs();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        blank         = 1'b0;
        a_data        = 24'h0;
        b_data        = 24'h0;
        c_data        = 24'h0;
        k             = 0;
        first_valid_a = -1;
        blank_px_a    = 0;
        b_last_fs     = -1;

        repeat (3) @(posedge pclk);
        #1;
        chk_out("a_rst_out", a_out_obs, idle_out(CA));
        chk_req("a_rst_req", a_req_obs, '0);
        chk_out("b_rst_out", b_out_obs, idle_out(CB));
        chk_out("c_rst_out", c_out_obs, idle_out(CC));

        @(negedge pclk);
        reset_n = 1'b1;
        start_run();

        // Config C: last active line (v_addr 479), then h_addr 17 on it.
        run_to(481 * 21 + 2);
        chk_int("c_v_addr_479", int'(c_v_addr), 479);
        chk_int("c_cell_y_479", int'(c_cell_y), 29);
        chk_int("c_cell_py_479", int'(c_cell_py), 15);
        run_to(481 * 21 + 19);
        chk_int("c_cell_x_h17", int'(c_cell_x), 1);
        chk_int("c_cell_px_h17", int'(c_cell_px), 8);

        // Config A: first active line starts at request cycle 35*800+144.
        run_to(28144 + 8);
        chk_int("a_cell_x_h8", int'(a_cell_x), 0);
        chk_int("a_cell_px_h8", int'(a_cell_px), 8);
        run_to(28144 + 9);
        chk_int("a_cell_x_h9", int'(a_cell_x), 1);
        chk_int("a_cell_px_h9", int'(a_cell_px), 0);
        run_to(28144 + 100);
        blank = 1'b1;
        run_to(28144 + 110);
        blank = 1'b0;
        run_to(28144 + 639);
        chk_int("a_cell_x_h639", int'(a_cell_x), 71);
        chk_int("a_cell_px_h639", int'(a_cell_px), 0);

        // Mid-frame reset at hc=400 on line 36.
        run_to(36 * 800 + 400);
        chk_int("a_first_valid", first_valid_a, 35 * 800 + 147);
        chk_int("a_blank_pixels", blank_px_a, 10);
        chk_int("a_h_addr_pre_rst", int'(a_h_addr), 256);
        reset_n = 1'b0;
        #2;
        chk_out("a_async_rst_out", a_out_obs, idle_out(CA));
        chk_req("a_async_rst_req", a_req_obs, '0);
        chk_out("b_async_rst_out", b_out_obs, idle_out(CB));
        chk_out("c_async_rst_out", c_out_obs, idle_out(CC));
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        reset_n = 1'b1;
        start_run();
        run_to(CA.lat + 1);
        chk_int("a_fs_after_rst", int'(a_frame_start), 1);
        run_to(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
